// File: rtl/dllp_extractor.sv
// Extracts 8-byte DLLPs (SDP + 6 body + END) from classified 64-byte beats and
// queues their 6-byte payloads in a first-word-fall-through FIFO.
module dllp_extractor #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     beat_valid,
    input  logic [511:0]             Data_in,
    input  logic [191:0]             ByteType,
    output logic                     dllp_valid,
    input  logic                     dllp_ready,
    output logic [47:0]              dllp_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     err_pulse,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [2:0] BT_STP  = 3'b001;
    localparam logic [2:0] BT_TLPB = 3'b010;
    localparam logic [2:0] BT_TLPE = 3'b011;
    localparam logic [2:0] BT_SDP  = 3'b100;
    localparam logic [2:0] BT_DLB  = 3'b101;
    localparam logic [2:0] BT_DLE  = 3'b110;
    localparam logic [2:0] BT_EDB  = 3'b111;

    logic [2:0] byte_type [64];
    logic [7:0] byte_val  [64];

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_unpack
            assign byte_type[gi] = ByteType[3*gi +: 3];
            assign byte_val[gi]  = Data_in[8*gi +: 8];
        end
    endgenerate

    logic          coll_q, coll_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [47:0]   dbuf_q, dbuf_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [47:0]   mem_q [DEPTH];

    logic [47:0]   cand [8];
    logic [3:0]    ncand;
    logic          pop;
    logic [LW-1:0] space, npush;
    logic [3:0]    drops;
    logic [16:0]   drop_sum;

    // Walk the beat byte by byte; the assembly state is threaded through the loop.
    always_comb begin
        coll_d = coll_q;
        cnt_d  = cnt_q;
        dbuf_d = dbuf_q;
        err_d  = 1'b0;
        ncand  = 4'd0;
        for (int k = 0; k < 8; k++) cand[k] = '0;
        if (beat_valid) begin
            for (int i = 0; i < 64; i++) begin
                case (byte_type[i])
                    BT_SDP: begin
                        if (coll_d) err_d = 1'b1;
                        coll_d = 1'b1;
                        cnt_d  = 3'd0;
                    end
                    BT_DLB: begin
                        if (!coll_d) begin
                            err_d = 1'b1;
                        end else if (cnt_d < 3'd6) begin
                            dbuf_d[{cnt_d, 3'b000} +: 8] = byte_val[i];
                            cnt_d = cnt_d + 3'd1;
                        end else begin
                            err_d  = 1'b1;
                            coll_d = 1'b0;
                        end
                    end
                    BT_DLE: begin
                        if (coll_d && cnt_d == 3'd6) begin
                            cand[ncand[2:0]] = dbuf_d;
                            ncand = ncand + 4'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                        coll_d = 1'b0;
                    end
                    BT_STP, BT_TLPB, BT_TLPE: begin
                        if (coll_d) err_d = 1'b1;
                        coll_d = 1'b0;
                    end
                    BT_EDB:  coll_d = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // A pop this cycle frees a slot for the same edge's pushes; oldest candidates win.
    always_comb begin
        pop      = (level_q != '0) && dllp_ready;
        space    = LW'(DEPTH) - level_q + {{(LW-1){1'b0}}, pop};
        npush    = (LW'(ncand) > space) ? space : LW'(ncand);
        drops    = ncand - npush[3:0];
        level_d  = level_q + npush - {{(LW-1){1'b0}}, pop};
        ovf_d    = ovf_q | (drops != 4'd0);
        drop_sum = {1'b0, drop_q} + {13'd0, drops};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coll_q   <= 1'b0;
            cnt_q    <= 3'd0;
            dbuf_q   <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            coll_q   <= coll_d;
            cnt_q    <= cnt_d;
            dbuf_q   <= dbuf_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, pop};
            wr_ptr_q <= wr_ptr_q + npush[PW-1:0];
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (LW'(k) < npush) mem_q[wr_ptr_q + PW'(k)] <= cand[k];
        end
    end

    assign dllp_valid = (level_q != '0);
    assign dllp_data  = dllp_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign err_pulse  = err_q;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_dllp_extractor.sv
// Directed bench for dllp_extractor: single, straddling, packed, malformed,
// overflow and mid-DLLP reset scenarios.
module tb_dllp_extractor;
    localparam int DEPTH = 16;
    localparam logic [2:0] SDP  = 3'b100;
    localparam logic [2:0] BODY = 3'b101;
    localparam logic [2:0] ENDB = 3'b110;
    localparam logic [2:0] STP  = 3'b001;
    localparam logic [2:0] EDB  = 3'b111;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         beat_valid = 1'b0;
    logic         dllp_ready = 1'b0;
    logic [511:0] data_in = '0;
    logic [191:0] byte_type = '0;
    logic         dllp_valid;
    logic [47:0]  dllp_data;
    logic [4:0]   fifo_level;
    logic         err_pulse;
    logic         overflow;
    logic [15:0]  drop_cnt;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    dllp_extractor #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .beat_valid (beat_valid),
        .Data_in    (data_in),
        .ByteType   (byte_type),
        .dllp_valid (dllp_valid),
        .dllp_ready (dllp_ready),
        .dllp_data  (dllp_data),
        .fifo_level (fifo_level),
        .err_pulse  (err_pulse),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        data_in   = '0;
        byte_type = '0;
    endtask

    task automatic put(input int idx, input logic [2:0] t, input logic [7:0] v);
        byte_type[3*idx +: 3] = t;
        data_in[8*idx +: 8]   = v;
    endtask

    // Back-to-back DLLPs starting at first_byte; body byte k of DLLP d = seed + 8d + k.
    task automatic dllps(input int first_byte, input int count, input logic [7:0] seed);
        for (int d = 0; d < count; d++) begin
            put(first_byte + 8*d, SDP, 8'h00);
            for (int k = 0; k < 6; k++) put(first_byte + 8*d + 1 + k, BODY, 8'(seed + 8*d + k));
            put(first_byte + 8*d + 7, ENDB, 8'h00);
        end
    endtask

    function automatic logic [47:0] expd(input logic [7:0] seed, input int d);
        logic [47:0] r;
        for (int k = 0; k < 6; k++) r[8*k +: 8] = 8'(seed + 8*d + k);
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic send(input logic pop_now);
        beat_valid = 1'b1;
        dllp_ready = pop_now;
        @(negedge clk);
        beat_valid = 1'b0;
        dllp_ready = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [47:0] exp);
        chk(tag, {16'd0, dllp_data}, {16'd0, exp});
        dllp_ready = 1'b1;
        @(negedge clk);
        dllp_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, dllp_valid}, 64'd0);
        chk("rst_data",  {16'd0, dllp_data}, 64'd0);
        chk("rst_level", {59'd0, fifo_level}, 64'd0);
        chk("rst_err",   {63'd0, err_pulse}, 64'd0);
        chk("rst_ovf",   {63'd0, overflow}, 64'd0);
        chk("rst_drop",  {48'd0, drop_cnt}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single DLLP at bytes 4..11
        clr();
        put(4, SDP, 8'h00);
        put(5, BODY, 8'h11); put(6, BODY, 8'h22); put(7, BODY, 8'h33);
        put(8, BODY, 8'h44); put(9, BODY, 8'h55); put(10, BODY, 8'h66);
        put(11, ENDB, 8'h00);
        send(1'b0);
        $display("[TB] single DLLP beat sent");
        chk("single_valid", {63'd0, dllp_valid}, 64'd1);
        chk("single_level", {59'd0, fifo_level}, 64'd1);
        chk("single_err",   {63'd0, err_pulse}, 64'd0);
        @(negedge clk);
        chk("single_hold", {16'd0, dllp_data}, 64'h665544332211);
        pop_chk("single_data", 48'h665544332211);
        chk("single_popped", {59'd0, fifo_level}, 64'd0);
        chk("single_empty",  {63'd0, dllp_valid}, 64'd0);

        // DLLP straddling two beats
        clr();
        put(60, SDP, 8'h00);
        put(61, BODY, 8'hA1); put(62, BODY, 8'hA2); put(63, BODY, 8'hA3);
        send(1'b0);
        chk("straddle_mid_level", {59'd0, fifo_level}, 64'd0);
        clr();
        put(0, BODY, 8'hA4); put(1, BODY, 8'hA5); put(2, BODY, 8'hA6);
        put(3, ENDB, 8'h00);
        send(1'b0);
        $display("[TB] straddle DLLP completed");
        chk("straddle_level", {59'd0, fifo_level}, 64'd1);
        chk("straddle_err",   {63'd0, err_pulse}, 64'd0);
        pop_chk("straddle_data", 48'hA6A5A4A3A2A1);

        // Eight DLLPs filling a whole beat
        clr();
        dllps(0, 8, 8'h01);
        send(1'b0);
        $display("[TB] eight-DLLP beat sent");
        chk("eight_level", {59'd0, fifo_level}, 64'd8);
        for (int d = 0; d < 8; d++) pop_chk($sformatf("eight_pop%0d", d), expd(8'h01, d));
        chk("eight_drained", {59'd0, fifo_level}, 64'd0);

        // Malformed: SDP + 4 bodies + END
        clr();
        put(0, SDP, 8'h00);
        for (int k = 1; k <= 4; k++) put(k, BODY, 8'(k));
        put(5, ENDB, 8'h00);
        send(1'b0);
        $display("[TB] short DLLP sent");
        chk("short_err",   {63'd0, err_pulse}, 64'd1);
        chk("short_level", {59'd0, fifo_level}, 64'd0);
        @(negedge clk);
        chk("short_err_clear", {63'd0, err_pulse}, 64'd0);

        // Malformed: SDP + 2 bodies + STP
        clr();
        put(0, SDP, 8'h00); put(1, BODY, 8'h01); put(2, BODY, 8'h02); put(3, STP, 8'h00);
        send(1'b0);
        $display("[TB] STP-interrupted DLLP sent");
        chk("stp_err",   {63'd0, err_pulse}, 64'd1);
        chk("stp_level", {59'd0, fifo_level}, 64'd0);

        // EDB aborts silently
        clr();
        put(0, SDP, 8'h00); put(1, BODY, 8'h01); put(2, BODY, 8'h02); put(3, BODY, 8'h03);
        put(4, EDB, 8'h00);
        send(1'b0);
        $display("[TB] EDB-aborted DLLP sent");
        chk("edb_err",   {63'd0, err_pulse}, 64'd0);
        chk("edb_level", {59'd0, fifo_level}, 64'd0);

        // Overflow: fill to 12, then 8 more with no pop -> 4 kept, 4 dropped
        clr(); dllps(0, 8, 8'h40); send(1'b0);
        clr(); dllps(0, 4, 8'h80); send(1'b0);
        chk("ovf_fill_level", {59'd0, fifo_level}, 64'd12);
        chk("ovf_pre",        {63'd0, overflow}, 64'd0);
        clr(); dllps(0, 8, 8'hA0); send(1'b0);
        $display("[TB] overflow beat sent without pop");
        chk("ovf1_level", {59'd0, fifo_level}, 64'd16);
        chk("ovf1_drop",  {48'd0, drop_cnt}, 64'd4);
        chk("ovf1_flag",  {63'd0, overflow}, 64'd1);
        for (int d = 0; d < 4; d++) pop_chk($sformatf("ovf_pop_a%0d", d), expd(8'h40, d));
        chk("ovf_refill_level", {59'd0, fifo_level}, 64'd12);
        clr(); dllps(0, 8, 8'hC0); send(1'b1);
        $display("[TB] overflow beat sent with pop");
        chk("ovf2_level", {59'd0, fifo_level}, 64'd16);
        chk("ovf2_drop",  {48'd0, drop_cnt}, 64'd7);
        chk("ovf2_flag",  {63'd0, overflow}, 64'd1);
        for (int d = 5; d < 8; d++) pop_chk($sformatf("drain_a%0d", d), expd(8'h40, d));
        for (int d = 0; d < 4; d++) pop_chk($sformatf("drain_b%0d", d), expd(8'h80, d));
        for (int d = 0; d < 4; d++) pop_chk($sformatf("drain_c%0d", d), expd(8'hA0, d));
        for (int d = 0; d < 5; d++) pop_chk($sformatf("drain_d%0d", d), expd(8'hC0, d));
        chk("drain_level", {59'd0, fifo_level}, 64'd0);
        chk("drain_ovf_sticky", {63'd0, overflow}, 64'd1);

        // Reset in the middle of a DLLP with one entry queued
        clr(); dllps(0, 1, 8'h20); send(1'b0);
        clr();
        put(0, SDP, 8'h00); put(1, BODY, 8'h01); put(2, BODY, 8'h02); put(3, BODY, 8'h03);
        send(1'b0);
        chk("prerst_level", {59'd0, fifo_level}, 64'd1);
        reset_n = 1'b0;
        #1;
        $display("[TB] reset asserted mid-DLLP");
        chk("midrst_valid", {63'd0, dllp_valid}, 64'd0);
        chk("midrst_data",  {16'd0, dllp_data}, 64'd0);
        chk("midrst_level", {59'd0, fifo_level}, 64'd0);
        chk("midrst_err",   {63'd0, err_pulse}, 64'd0);
        chk("midrst_ovf",   {63'd0, overflow}, 64'd0);
        chk("midrst_drop",  {48'd0, drop_cnt}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clr();
        put(0, BODY, 8'h04); put(1, BODY, 8'h05); put(2, BODY, 8'h06); put(3, ENDB, 8'h00);
        send(1'b0);
        $display("[TB] stray tail sent after reset");
        chk("tail_err",   {63'd0, err_pulse}, 64'd1);
        chk("tail_level", {59'd0, fifo_level}, 64'd0);
        chk("tail_valid", {63'd0, dllp_valid}, 64'd0);
        @(negedge clk);
        chk("tail_err_clear", {63'd0, err_pulse}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
